// File: rtl/w5300_bus_master.sv
// Host-bus master for the W5300 parallel interface: one request of 1..MAX_BYTES bytes
// becomes a train of CS/RD/WR beats with programmable setup, strobe and hold timing.
module w5300_bus_master #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int MAX_BYTES  = 4,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_write,
    input  logic                           req_fixed,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [$clog2(MAX_BYTES+1)-1:0] req_len,
    input  logic [8*MAX_BYTES-1:0]         req_wdata,
    output logic                           rsp_valid,
    output logic [8*MAX_BYTES-1:0]         rsp_rdata,
    output logic                           busy,
    output logic [ADDR_W-1:0]              addr,
    output logic                           cs_n,
    output logic                           rd_n,
    output logic                           wr_n,
    output logic [DATA_W-1:0]              data_o,
    output logic                           data_oe,
    input  logic [DATA_W-1:0]              data_i
);

    localparam int BYTES   = DATA_W / 8;
    localparam int LEN_W   = $clog2(MAX_BYTES + 1);
    localparam int DW      = 8 * MAX_BYTES;
    localparam int BEAT_SH = (DATA_W == 16) ? 1 : 0;
    localparam logic [LEN_W-1:0] MAX_LEN     = LEN_W'(MAX_BYTES);
    localparam logic [3:0]       SETUP_LAST  = 4'(SETUP_CYC - 1);
    localparam logic [3:0]       STROBE_LAST = 4'(STROBE_CYC - 1);
    localparam logic [3:0]       HOLD_LAST   = 4'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg;
    logic              write_reg, fixed_reg, odd_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  beats_reg;
    logic [DW-1:0]     wshift_reg, rshift_reg, rshift_next, rdata_reg;
    logic [LEN_W-1:0]  len_eff;
    logic [LEN_W:0]    beats_calc;
    logic              accept, last_beat, strobe_end, beat_end, sample, active;

    assign accept     = (state_reg == IDLE) && req_valid;
    assign len_eff    = (req_len == '0 || req_len > MAX_LEN) ? MAX_LEN : req_len;
    assign beats_calc = ({1'b0, len_eff} + (LEN_W+1)'(BYTES - 1)) >> BEAT_SH;
    assign last_beat  = (beats_reg == LEN_W'(1));
    assign strobe_end = (state_reg == STROBE) && (cnt_reg == STROBE_LAST);
    assign beat_end   = ((state_reg == HOLD) && (cnt_reg == HOLD_LAST)) ||
                        ((HOLD_CYC == 0) && strobe_end);
    // Read data is captured on the edge that closes the last strobe cycle.
    assign sample     = strobe_end && !write_reg;
    assign active     = (state_reg == SETUP) || (state_reg == STROBE) || (state_reg == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= (state_next != state_reg) ? 4'd0 : cnt_reg + 4'd1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = SETUP;
            SETUP:   if (cnt_reg == SETUP_LAST) state_next = STROBE;
            STROBE:  if (strobe_end) begin
                         if (HOLD_CYC != 0) state_next = HOLD;
                         else               state_next = last_beat ? DONE : SETUP;
                     end
            HOLD:    if (beat_end) state_next = last_beat ? DONE : SETUP;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rshift_next = rshift_reg;
        if (sample) rshift_next = (rshift_reg << DATA_W) | DW'(data_i);
    end

    // Write data is left-justified on acceptance so each beat takes the top lane(s);
    // zeros shifted in fill the unused low lane of an odd-length 16-bit transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_reg  <= 1'b0;
            fixed_reg  <= 1'b0;
            odd_reg    <= 1'b0;
            addr_reg   <= '0;
            beats_reg  <= '0;
            wshift_reg <= '0;
            rshift_reg <= '0;
            rdata_reg  <= '0;
        end else begin
            if (accept) begin
                write_reg  <= req_write;
                fixed_reg  <= req_fixed;
                odd_reg    <= (BYTES == 2) && len_eff[0];
                addr_reg   <= req_addr;
                beats_reg  <= beats_calc[LEN_W-1:0];
                wshift_reg <= req_wdata << {MAX_LEN - len_eff, 3'b000};
                rshift_reg <= '0;
            end else begin
                rshift_reg <= rshift_next;
                if (beat_end) begin
                    beats_reg  <= beats_reg - LEN_W'(1);
                    wshift_reg <= wshift_reg << DATA_W;
                    if (!fixed_reg && !last_beat) addr_reg <= addr_reg + ADDR_W'(BYTES);
                end
            end
            if (state_next == DONE && !write_reg)
                rdata_reg <= odd_reg ? (rshift_next >> 8) : rshift_next;
        end
    end

    always_comb begin
        req_ready = (state_reg == IDLE);
        busy      = (state_reg != IDLE);
        rsp_valid = (state_reg == DONE);
        cs_n      = !active;
        rd_n      = !((state_reg == STROBE) && !write_reg);
        wr_n      = !((state_reg == STROBE) && write_reg);
        data_oe   = active && write_reg;
        data_o    = (active && write_reg) ? wshift_reg[DW-1 -: DATA_W] : '0;
    end

    assign addr      = addr_reg;
    assign rsp_rdata = rdata_reg;

endmodule

// File: tb/tb_w5300_bus_master.sv
// Scoreboard bench for w5300_bus_master: three instances (8-bit 1/3/1, 16-bit 1/3/1,
// 8-bit 2/5/0) driven by directed vectors; a negedge monitor checks each completion.
module tb_w5300_bus_master;

    localparam int N = 3;

    typedef struct packed {
        int               inst;
        logic             wr;
        int               lat;
        int               beats;
        logic [31:0]      rdata;
        logic [3:0][9:0]  addrs;
        logic [3:0][15:0] words;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic        req_valid [N];
    logic        req_write [N];
    logic        req_fixed [N];
    logic [9:0]  req_addr  [N];
    logic [2:0]  req_len   [N];
    logic [31:0] req_wdata [N];
    logic        req_ready [N];
    logic        rsp_valid [N];
    logic [31:0] rsp_rdata [N];
    logic        busy      [N];
    logic [9:0]  addr      [N];
    logic        cs_n      [N];
    logic        rd_n      [N];
    logic        wr_n      [N];
    logic        data_oe   [N];
    logic [15:0] dout      [N];
    logic [15:0] din       [N];
    logic [7:0]  dout0, dout2;
    logic [15:0] dout1;

    int cyc = 0, tests = 0, fails = 0;
    int beat [N], slen [N], acc_cyc [N];
    logic in_txn [N], cs_gap [N], proto [N], sw_err [N];
    logic [3:0][9:0]  log_addr  [N];
    logic [3:0][15:0] log_data  [N];
    logic [3:0][15:0] bus_words [N];
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    w5300_bus_master #(.ADDR_W(10), .DATA_W(8), .MAX_BYTES(4),
                       .SETUP_CYC(1), .STROBE_CYC(3), .HOLD_CYC(1)) u_dut8 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_fixed(req_fixed[0]), .req_addr(req_addr[0]),
        .req_len(req_len[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_rdata(rsp_rdata[0]), .busy(busy[0]), .addr(addr[0]), .cs_n(cs_n[0]),
        .rd_n(rd_n[0]), .wr_n(wr_n[0]), .data_o(dout0), .data_oe(data_oe[0]),
        .data_i(din[0][7:0]));

    w5300_bus_master #(.ADDR_W(10), .DATA_W(16), .MAX_BYTES(4),
                       .SETUP_CYC(1), .STROBE_CYC(3), .HOLD_CYC(1)) u_dut16 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_fixed(req_fixed[1]), .req_addr(req_addr[1]),
        .req_len(req_len[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_rdata(rsp_rdata[1]), .busy(busy[1]), .addr(addr[1]), .cs_n(cs_n[1]),
        .rd_n(rd_n[1]), .wr_n(wr_n[1]), .data_o(dout1), .data_oe(data_oe[1]),
        .data_i(din[1]));

    w5300_bus_master #(.ADDR_W(10), .DATA_W(8), .MAX_BYTES(4),
                       .SETUP_CYC(2), .STROBE_CYC(5), .HOLD_CYC(0)) u_dut_nohold (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_write(req_write[2]), .req_fixed(req_fixed[2]), .req_addr(req_addr[2]),
        .req_len(req_len[2]), .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]),
        .rsp_rdata(rsp_rdata[2]), .busy(busy[2]), .addr(addr[2]), .cs_n(cs_n[2]),
        .rd_n(rd_n[2]), .wr_n(wr_n[2]), .data_o(dout2), .data_oe(data_oe[2]),
        .data_i(din[2][7:0]));

    assign dout[0] = {8'h00, dout0};
    assign dout[1] = dout1;
    assign dout[2] = {8'h00, dout2};

    // Bus model: each beat returns the word queued for that beat index.
    always_comb begin
        for (int i = 0; i < N; i++)
            din[i] = (beat[i] < 4) ? bus_words[i][beat[i][1:0]] : 16'h0000;
    end

    function automatic int strobe_w(input int i);
        return (i == 2) ? 5 : 3;
    endfunction

    task automatic chk(input string name, input int i, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s inst%0d: got %0h required %0h", name, i, got, exp);
        end
    endtask

    task automatic close_strobe(input int i);
        if (slen[i] != strobe_w(i)) sw_err[i] = 1'b1;
        beat[i]++;
        slen[i] = 0;
    endtask

    task automatic check_rsp(input int i);
        exp_t e;
        if (slen[i] > 0) close_strobe(i);
        in_txn[i] = 1'b0;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rsp inst%0d: got rsp_valid=1 required no response", i);
        end else begin
            e = sb.pop_front();
            chk("instance", i, 64'(i), 64'(e.inst));
            chk("latency", i, 64'(cyc - acc_cyc[i]), 64'(e.lat));
            chk("beats", i, 64'(beat[i]), 64'(e.beats));
            chk("strobe_width", i, 64'(sw_err[i]), 64'd0);
            chk("cs_continuous", i, 64'(cs_gap[i]), 64'd0);
            chk("protocol", i, 64'(proto[i]), 64'd0);
            for (int k = 0; k < e.beats && k < 4; k++) begin
                chk("beat_addr", i, 64'(log_addr[i][k[1:0]]), 64'(e.addrs[k[1:0]]));
                if (e.wr) chk("beat_wdata", i, 64'(log_data[i][k[1:0]]), 64'(e.words[k[1:0]]));
            end
            chk("rsp_rdata", i, 64'(rsp_rdata[i]), 64'(e.rdata));
            $display("[TB] inst%0d %s addr0=%03h beats=%0d latency=%0d rdata=%08h",
                     i, e.wr ? "write" : "read ", e.addrs[0], beat[i], cyc - acc_cyc[i], rsp_rdata[i]);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if ((!rd_n[i] && !wr_n[i]) || (data_oe[i] && (!rd_n[i] || cs_n[i]))) proto[i] = 1'b1;
            if (rst) begin
                in_txn[i] = 1'b0;
                slen[i]   = 0;
            end else begin
                if (rsp_valid[i]) check_rsp(i);
                else if (in_txn[i]) begin
                    if (cs_n[i]) cs_gap[i] = 1'b1;
                    if (!rd_n[i] || !wr_n[i]) begin
                        if (slen[i] == 0 && beat[i] < 4) begin
                            log_addr[i][beat[i][1:0]] = addr[i];
                            log_data[i][beat[i][1:0]] = dout[i];
                            if (!wr_n[i] && !data_oe[i]) proto[i] = 1'b1;
                        end
                        slen[i]++;
                    end else if (slen[i] > 0) begin
                        close_strobe(i);
                    end
                end
                if (req_valid[i] && req_ready[i]) begin
                    in_txn[i]   = 1'b1;
                    beat[i]     = 0;
                    slen[i]     = 0;
                    cs_gap[i]   = 1'b0;
                    proto[i]    = 1'b0;
                    sw_err[i]   = 1'b0;
                    acc_cyc[i]  = cyc;
                    log_addr[i] = '0;
                    log_data[i] = '0;
                end
            end
        end
    end

    task automatic drive(input int i, input logic wr, input logic fx, input logic [9:0] a,
                         input logic [2:0] len, input logic [31:0] wd, input logic [3:0][15:0] words);
        bus_words[i]  = words;
        req_write[i]  = wr;
        req_fixed[i]  = fx;
        req_addr[i]   = a;
        req_len[i]    = len;
        req_wdata[i]  = wd;
        req_valid[i]  = 1'b1;
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (sb.size() > 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic issue(input int i, input logic wr, input logic fx, input logic [9:0] a,
                         input logic [2:0] len, input logic [31:0] wd, input logic [3:0][15:0] words,
                         input logic [3:0][9:0] addrs, input int beats, input int lat,
                         input logic [31:0] rdata);
        exp_t e;
        e.inst  = i;
        e.wr    = wr;
        e.lat   = lat;
        e.beats = beats;
        e.rdata = rdata;
        e.addrs = addrs;
        e.words = words;
        sb.push_back(e);
        drive(i, wr, fx, a, len, wd, words);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0; req_fixed[i] = 1'b0;
            req_addr[i] = '0; req_len[i] = '0; req_wdata[i] = '0;
            bus_words[i] = '0; in_txn[i] = 1'b0; beat[i] = 0; slen[i] = 0;
            cs_gap[i] = 1'b0; proto[i] = 1'b0; sw_err[i] = 1'b0; acc_cyc[i] = 0;
            log_addr[i] = '0; log_data[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk("reset_cs_n", i, 64'(cs_n[i]), 64'd1);
            chk("reset_rd_n", i, 64'(rd_n[i]), 64'd1);
            chk("reset_wr_n", i, 64'(wr_n[i]), 64'd1);
            chk("reset_data_oe", i, 64'(data_oe[i]), 64'd0);
            chk("reset_addr", i, 64'(addr[i]), 64'd0);
            chk("reset_data_o", i, 64'(dout[i]), 64'd0);
            chk("reset_rsp_valid", i, 64'(rsp_valid[i]), 64'd0);
            chk("reset_rsp_rdata", i, 64'(rsp_rdata[i]), 64'd0);
            chk("reset_busy", i, 64'(busy[i]), 64'd0);
            chk("reset_req_ready", i, 64'(req_ready[i]), 64'd1);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 8-bit bus, 1/3/1 timing: 5 clocks per beat
        issue(0, 1'b0, 1'b0, 10'h200, 3'd2, 32'h0, {16'h0, 16'h0, 16'h0022, 16'h0000},
              {10'h0, 10'h0, 10'h201, 10'h200}, 2, 11, 32'h0000_0022);
        issue(0, 1'b1, 1'b0, 10'h207, 3'd1, 32'h0000_0010, {16'h0, 16'h0, 16'h0, 16'h0010},
              {10'h0, 10'h0, 10'h0, 10'h207}, 1, 6, 32'h0000_0022);
        issue(0, 1'b0, 1'b0, 10'h220, 3'd4, 32'h0, {16'h00D0, 16'h0, 16'h0, 16'h0},
              {10'h223, 10'h222, 10'h221, 10'h220}, 4, 21, 32'h0000_00D0);
        issue(0, 1'b1, 1'b0, 10'h100, 3'd3, 32'h00AB_CDEF, {16'h0, 16'h00EF, 16'h00CD, 16'h00AB},
              {10'h0, 10'h102, 10'h101, 10'h100}, 3, 16, 32'h0000_00D0);

        // Abort a 4-byte read during its second strobe
        drive(0, 1'b0, 1'b0, 10'h000, 3'd4, 32'h0, {4{16'h00FF}});
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk);
            #1;
            if (!rd_n[0] && beat[0] == 1) found = 1'b1;
        end
        chk("abort_second_strobe_seen", 0, 64'(found), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_cs_n", 0, 64'(cs_n[0]), 64'd1);
        chk("abort_rd_n", 0, 64'(rd_n[0]), 64'd1);
        chk("abort_busy", 0, 64'(busy[0]), 64'd0);
        chk("abort_rsp_valid", 0, 64'(rsp_valid[0]), 64'd0);
        chk("abort_rsp_rdata", 0, 64'(rsp_rdata[0]), 64'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        issue(0, 1'b0, 1'b0, 10'h3FF, 3'd1, 32'h0, {16'h0, 16'h0, 16'h0, 16'h005A},
              {10'h0, 10'h0, 10'h0, 10'h3FF}, 1, 6, 32'h0000_005A);

        // 16-bit bus: FIFO burst, odd-length write and read
        issue(1, 1'b0, 1'b1, 10'h230, 3'd4, 32'h0, {16'h0, 16'h0, 16'h0001, 16'hC0A8},
              {10'h0, 10'h0, 10'h230, 10'h230}, 2, 11, 32'hC0A8_0001);
        issue(1, 1'b1, 1'b0, 10'h010, 3'd3, 32'h0011_2233, {16'h0, 16'h0, 16'h3300, 16'h1122},
              {10'h0, 10'h0, 10'h012, 10'h010}, 2, 11, 32'hC0A8_0001);
        issue(1, 1'b0, 1'b0, 10'h040, 3'd3, 32'h0, {16'h0, 16'h0, 16'hC3D4, 16'hA1B2},
              {10'h0, 10'h0, 10'h042, 10'h040}, 2, 11, 32'h00A1_B2C3);

        // 2/5/0 timing (7 clocks per beat, no HOLD): len=0, wrap, len>MAX
        issue(2, 1'b0, 1'b0, 10'h3FE, 3'd0, 32'h0, {16'h0044, 16'h0033, 16'h0022, 16'h0011},
              {10'h001, 10'h000, 10'h3FF, 10'h3FE}, 4, 29, 32'h1122_3344);
        issue(2, 1'b1, 1'b0, 10'h3FF, 3'd2, 32'h0000_BEEF, {16'h0, 16'h0, 16'h00EF, 16'h00BE},
              {10'h0, 10'h0, 10'h000, 10'h3FF}, 2, 15, 32'h1122_3344);
        issue(2, 1'b0, 1'b0, 10'h080, 3'd5, 32'h0, {16'h0004, 16'h0003, 16'h0002, 16'h0001},
              {10'h083, 10'h082, 10'h081, 10'h080}, 4, 29, 32'h0102_0304);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/w5300_bus_master.md
Name: w5300_bus_master

Overview:
Parametrised host-bus master for the W5300 TOE parallel interface. It turns single-request register/FIFO accesses of 1..MAX_BYTES bytes into timed CS/RD/WR bus cycles, in 8- or 16-bit bus mode, with programmable setup, strobe and hold timing. It sits between the UART command/INIT/UDP sequencers and the top-level tristate data pins.

Parameters:
ADDR_W, 10, bus address width.
DATA_W, 8, bus data width; legal values are 8 or 16.
MAX_BYTES, 4, maximum bytes per request; must be a multiple of DATA_W/8.
SETUP_CYC, 1, clocks with address valid and cs_n low before the strobe; legal range 1..15.
STROBE_CYC, 3, clocks with rd_n or wr_n low; legal range 1..15.
HOLD_CYC, 1, clocks after the strobe rises, with cs_n still low; legal range 0..15.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  access request
req_ready  out  1  high in IDLE only
req_write  in  1  1 = write, 0 = read
req_fixed  in  1  1 = hold the address for every beat (FIFO register); 0 = increment
req_addr  in  ADDR_W  start address; must be aligned to DATA_W/8
req_len  in  clog2(MAX_BYTES+1)  byte count, 1..MAX_BYTES
req_wdata  in  8*MAX_BYTES  write data, big-endian; the first bus byte is [8*len-1 -: 8]
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  8*MAX_BYTES  read data, right-justified, big-endian
busy  out  1  high whenever the FSM is not in IDLE
addr  out  ADDR_W  bus address
cs_n  out  1  chip select
rd_n  out  1  read strobe
wr_n  out  1  write strobe
data_o  out  DATA_W  bus write data
data_oe  out  1  data_o drive enable; the top level builds the tristate
data_i  in  DATA_W  bus read data

Behaviour:
- Reset values: cs_n=1, rd_n=1, wr_n=1, data_oe=0, addr=0, data_o=0, rsp_valid=0, rsp_rdata=0, busy=0. FSM goes to IDLE.
- Reset mid-transfer aborts the access the next clock. No rsp_valid pulse is produced.
- Acceptance: a request is accepted when req_valid && req_ready. All req_* fields are registered on acceptance.
- Invalid length: req_len=0 or req_len>MAX_BYTES is clamped to MAX_BYTES.
- Beat count: beats = ceil(len/(DATA_W/8)).
- Odd length in 16-bit mode: the final beat's low byte lane is ignored on read and driven 0x00 on write.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> (SETUP for the next beat | DONE) -> IDLE.
  - HOLD is skipped when HOLD_CYC=0.
  - DONE lasts one cycle and asserts rsp_valid.
- SETUP:
  - cs_n=0, strobes high, addr valid.
  - For writes, data_oe=1 and data_o carries the beat data.
  - Lasts SETUP_CYC clocks.
- STROBE:
  - rd_n or wr_n low for exactly STROBE_CYC clocks; addr and data are stable.
  - Reads sample data_i on the clock edge that ends the last strobe cycle, i.e. with the strobe still low.
- HOLD:
  - Strobe high, cs_n low, addr/data held, data_oe held for writes.
  - Lasts HOLD_CYC clocks.
- Between beats: cs_n stays low, strobes return high, and the next beat starts in SETUP.
- Address advance: when req_fixed=0, addr advances by DATA_W/8 per beat and wraps modulo 2^ADDR_W. When req_fixed=1, addr stays constant.
- Read assembly: bytes shift in MSB-first. rsp_rdata holds the last result until the next read completes; writes leave it unchanged.
- Transfer length: clocks from acceptance to rsp_valid = beats*(SETUP_CYC+STROBE_CYC+HOLD_CYC)+1.
- Back-to-back requests: a new request may be accepted the clock after DONE, so there is a minimum of 1 IDLE cycle with cs_n high between requests.
- data_oe is never high while rd_n is low.
- rd_n and wr_n are never low at the same time.

Test Plan:
- 8-bit read, addr=0x200, len=2, bus model returns 0x00 then 0x22 -> two rd_n pulses of 3 clocks each, addresses 0x200 and 0x201, rsp_rdata[15:0]=0x0022, rsp_valid exactly 11 clocks after acceptance.
- 8-bit write, addr=0x207, len=1, wdata=0x10 -> one wr_n pulse of 3 clocks, data_oe=1 only while cs_n=0, data_o=0x10, addr=0x207.
- 8-bit read, len=4, S0_RX_RSR bytes 0x00,0x00,0x00,0xD0 -> rsp_rdata=0x000000D0; cs_n stays low for all 4 beats.
- FIFO burst: DATA_W=16, req_fixed=1, addr=0x230, len=4, words 0xC0A8 then 0x0001 -> addr stays at 0x230 on both beats, rsp_rdata=0xC0A80001.
- Reset mid-transfer: assert rst during the second STROBE of a len=4 read -> next clock cs_n=rd_n=1, busy=0, no rsp_valid. A new request is accepted after rst drops.
- Parameter sweep SETUP/STROBE/HOLD = 2/5/0 plus the length edge cases -> HOLD is skipped, timing matches the formula, and:
  - len=0 is treated as 4;
  - address wrap: 0x3FF + 1 -> 0x000.
